// File: rtl/branch_pattern_table.sv
// Gshare pattern history table: 2-bit saturating counters indexed by
// PC XOR global history, with a combinational lookup port, an independent
// update port and update/mispredict statistics.
module branch_pattern_table #(
  parameter int INDEX_BITS = 7,
  parameter int HIST_BITS  = 7,
  parameter int PC_LSB     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] lookup_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic [31:0]           mispredict_count,
  output logic [31:0]           update_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            pht [ENTRIES];
  logic [HIST_BITS-1:0]  ghr;
  logic [HIST_BITS-1:0]  ghr_next;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [1:0]            upd_cur;
  logic [1:0]            upd_new;
  logic [1:0]            look_cnt;
  logic                  bypass;
  logic                  unused_pc;

  // Saturating 2-bit counter step: moves toward 11 on taken, 00 on not-taken.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else       res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    return res;
  endfunction

  // Only the index bits of the PC feed the table; the rest are deliberately ignored.
  assign unused_pc = ^lookup_pc;

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_next = update_taken;
    end else begin : g_histn
      assign ghr_next = {ghr[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  // Zero-extend the history into the low bits of the index and hash with the PC.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr;
    lookup_index = lookup_pc[PC_LSB +: INDEX_BITS] ^ ghr_ext;
  end

  // Lookup with same-cycle bypass of a concurrent update to the same entry.
  always_comb begin
    upd_cur  = pht[update_index];
    upd_new  = sat_next(upd_cur, update_taken);
    bypass   = update_valid && (update_index == lookup_index);
    look_cnt = bypass ? upd_new : pht[lookup_index];
    predict_taken = !rst && lookup_valid && look_cnt[1];
  end

  // Counter table: one entry trained per accepted update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (update_valid) begin
      pht[update_index] <= upd_new;
    end
  end

  // Global history shifts in resolved outcomes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ghr <= '0;
    else if (update_valid) ghr <= ghr_next;
  end

  // Update and mispredict statistics, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      update_count <= update_count + 32'd1;
      if (update_mispredict) mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_pattern_table.sv
// Directed bench for branch_pattern_table with hand-computed expectations.
module tb_branch_pattern_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [6:0]  lookup_index;
  logic        update_valid;
  logic [6:0]  update_index;
  logic        update_taken;
  logic        update_mispredict;
  logic [31:0] mispredict_count;
  logic [31:0] update_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_pattern_table #(.INDEX_BITS(7), .HIST_BITS(7), .PC_LSB(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .predict_taken     (predict_taken),
    .lookup_index      (lookup_index),
    .update_valid      (update_valid),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .mispredict_count  (mispredict_count),
    .update_count      (update_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic upd(input logic [6:0] idx, input logic taken, input logic misp);
    @(negedge clk);
    update_valid = 1'b1; update_index = idx; update_taken = taken; update_mispredict = misp;
    @(posedge clk);
    #1;
    update_valid = 1'b0; update_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    lookup_pc = pc; lookup_valid = 1'b1;
    #1;
  endtask

  // Combinational probe: what the prediction would be if idx were trained taken now.
  task automatic probe(input logic [6:0] idx, input logic [31:0] pc, input string tag, input logic exp);
    @(negedge clk);
    update_valid = 1'b1; update_index = idx; update_taken = 1'b1;
    lookup_pc = pc; lookup_valid = 1'b1;
    #1;
    check(tag, {31'd0, predict_taken}, {31'd0, exp});
    update_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_index = '0; update_taken = 1'b0; update_mispredict = 1'b0;
    #1;
    check("rst_pred", {31'd0, predict_taken}, 32'd0);
    check("rst_ucnt", update_count, 32'd0);
    check("rst_mcnt", mispredict_count, 32'd0);
    do_reset();

    // Reset sweep over all entries.
    for (int i = 0; i < 128; i++) begin
      look(32'(i * 4));
      check("sweep_pred", {31'd0, predict_taken}, 32'd0);
      check("sweep_idx", {25'd0, lookup_index}, 32'(i));
    end
    lookup_valid = 1'b0;
    #1;
    check("invalid_pred", {31'd0, predict_taken}, 32'd0);

    // Two taken updates to index 5: 01 -> 10 -> 11, GHR = 0000011.
    upd(7'd5, 1'b1, 1'b0);
    upd(7'd5, 1'b1, 1'b0);
    look(32'h18);
    check("ghr3_idx", {25'd0, lookup_index}, 32'd5);
    check("ghr3_pred", {31'd0, predict_taken}, 32'd1);
    check("ucnt2", update_count, 32'd2);
    for (int i = 0; i < 7; i++) upd(7'd100, 1'b0, 1'b0);
    look(32'h14);
    check("idx5", {25'd0, lookup_index}, 32'd5);
    check("pred5_11", {31'd0, predict_taken}, 32'd1);
    check("ucnt9", update_count, 32'd9);

    // Saturating down from 11, then one taken.
    upd(7'd5, 1'b0, 1'b0);
    look(32'h14);
    check("dn1_pred", {31'd0, predict_taken}, 32'd1);
    upd(7'd5, 1'b0, 1'b0);
    look(32'h14);
    check("dn2_pred", {31'd0, predict_taken}, 32'd0);
    probe(7'd5, 32'h14, "dn2_state01", 1'b1);
    upd(7'd5, 1'b0, 1'b0);
    look(32'h14);
    check("dn3_pred", {31'd0, predict_taken}, 32'd0);
    probe(7'd5, 32'h14, "dn3_state00", 1'b0);
    upd(7'd5, 1'b0, 1'b0);
    look(32'h14);
    check("dn4_pred", {31'd0, predict_taken}, 32'd0);
    probe(7'd5, 32'h14, "dn4_sat00", 1'b0);
    upd(7'd5, 1'b1, 1'b0);
    look(32'h10);
    check("up_idx", {25'd0, lookup_index}, 32'd5);
    check("up_pred", {31'd0, predict_taken}, 32'd0);
    probe(7'd5, 32'h10, "up_state01", 1'b1);
    check("ucnt14", update_count, 32'd14);

    // Same-cycle bypass on index 9.
    do_reset();
    look(32'h24);
    check("byp_before", {31'd0, predict_taken}, 32'd0);
    update_valid = 1'b1; update_index = 7'd9; update_taken = 1'b1;
    #1;
    check("byp_idx", {25'd0, lookup_index}, 32'd9);
    check("byp_pred", {31'd0, predict_taken}, 32'd1);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    look(32'h20);
    check("byp_after_idx", {25'd0, lookup_index}, 32'd9);
    check("byp_after_pred", {31'd0, predict_taken}, 32'd1);

    // History and mispredict accounting.
    do_reset();
    upd(7'd20, 1'b1, 1'b1);
    upd(7'd21, 1'b0, 1'b0);
    upd(7'd22, 1'b1, 1'b1);
    look(32'h0);
    check("ghr_idx", {25'd0, lookup_index}, 32'h05);
    check("ghr_ucnt", update_count, 32'd3);
    check("ghr_mcnt", mispredict_count, 32'd2);
    @(negedge clk);
    update_mispredict = 1'b1;
    @(posedge clk);
    #1;
    update_mispredict = 1'b0;
    check("misp_noval", mispredict_count, 32'd2);
    check("ucnt_noval", update_count, 32'd3);

    // Asynchronous reset between edges with an update pending.
    look(32'h58);
    update_valid = 1'b1; update_index = 7'd22; update_taken = 1'b1; update_mispredict = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("arst_ucnt", update_count, 32'd0);
    check("arst_mcnt", mispredict_count, 32'd0);
    check("arst_pred", {31'd0, predict_taken}, 32'd0);
    check("arst_idx", {25'd0, lookup_index}, 32'd22);
    @(negedge clk);
    update_valid = 1'b0; update_mispredict = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_pred", {31'd0, predict_taken}, 32'd0);
    check("post_rst_ucnt", update_count, 32'd0);
    look(32'h0);
    check("post_rst_ghr", {25'd0, lookup_index}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
